// File: rtl/jh_e8_engine.sv
// jh_e8_engine: iterative JH E8 permutation core. Applies UNROLL R8 rounds per clock
// with an on-the-fly R6 round-constant generator and an optional S-box-only half round.
//
// state | meaning
// IDLE  | waiting for a state to load; in_ready high
// RUN   | UNROLL R8 rounds and UNROLL constant updates per cycle
// HALF  | one substitution-only layer with the final constant
// DONE  | result held on state_out until out_ready
module jh_e8_engine #(
    parameter int           ROUNDS     = 42,
    parameter int           UNROLL     = 1,
    parameter int           FINAL_HALF = 0,
    parameter logic [255:0] C0         = 256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] state_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] state_out,
    output logic          busy
);

    localparam int             CW       = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0]  CNT_STEP = CW'(UNROLL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ROUNDS - UNROLL);
    localparam logic [63:0]    S0_TAB   = 64'he857_62a1_f3cd_b409;
    localparam logic [63:0]    S1_TAB   = 64'h8eab_402f_9175_d6c3;

    if (ROUNDS % UNROLL != 0) begin : g_bad_params
        $error("jh_e8_engine: ROUNDS must be a multiple of UNROLL");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALF, S_DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           load;
    logic           adv;
    logic           half;
    logic [1023:0]  st_q;
    logic [255:0]   rc;
    logic [CW-1:0]  cnt;
    logic [1023:0]  st_run;
    logic [255:0]   rc_run;

    function automatic logic [3:0] gf_mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [3:0] sbox(input logic sel, input logic [3:0] x);
        return sel ? S1_TAB[{x, 2'b00} +: 4] : S0_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [1023:0] sub_layer(input logic [1023:0] a, input logic [255:0] sel);
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[4*i +: 4] = sbox(sel[i], a[4*i +: 4]);
        end
        return r;
    endfunction

    // Linear layer, initial swap, pi permutation and final swap over the low n nibbles.
    // Only the L step is logic; the three reorderings are pure wiring.
    function automatic logic [1023:0] mix(input logic [1023:0] v, input int n);
        logic [1023:0] w;
        logic [1023:0] x;
        logic [1023:0] p;
        logic [1023:0] q;
        logic [3:0]    b;
        int            h;
        int            q4;
        h  = n / 2;
        q4 = n / 4;
        w  = '0;
        x  = '0;
        p  = '0;
        b  = '0;
        for (int j = 0; j < 128; j++) begin
            if (j < h) begin
                b               = v[8*j+4 +: 4] ^ gf_mul2(v[8*j +: 4]);
                w[8*j +: 4]     = v[8*j +: 4] ^ gf_mul2(b);
                w[8*j+4 +: 4]   = b;
            end
        end
        for (int k = 0; k < 64; k++) begin
            if (k < q4) begin
                x[16*k +: 8]      = w[16*k +: 8];
                x[16*k+8 +: 4]    = w[16*k+12 +: 4];
                x[16*k+12 +: 4]   = w[16*k+8 +: 4];
            end
        end
        for (int i = 0; i < 128; i++) begin
            if (i < h) begin
                p[4*i +: 4]       = x[8*i +: 4];
                p[4*(i+h) +: 4]   = x[8*i+4 +: 4];
            end
        end
        q = p;
        for (int k = 0; k < 64; k++) begin
            if (k < q4) begin
                q[4*(h+2*k) +: 4]   = p[4*(h+2*k+1) +: 4];
                q[4*(h+2*k+1) +: 4] = p[4*(h+2*k) +: 4];
            end
        end
        return q;
    endfunction

    function automatic logic [255:0] r6(input logic [255:0] c);
        return 256'(mix(sub_layer({768'b0, c}, '0), 64));
    endfunction

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [1023:0] st_src;
        logic [1023:0] st_nxt;
        logic [255:0]  rc_src;
        logic [255:0]  rc_nxt;
        if (g == 0) begin : g_first
            assign st_src = st_q;
            assign rc_src = rc;
        end else begin : g_chain
            assign st_src = g_round[g-1].st_nxt;
            assign rc_src = g_round[g-1].rc_nxt;
        end
        assign st_nxt = mix(sub_layer(st_src, rc_src), 256);
        assign rc_nxt = r6(rc_src);
    end

    assign st_run = g_round[UNROLL-1].st_nxt;
    assign rc_run = g_round[UNROLL-1].rc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        half      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                adv  = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = (FINAL_HALF != 0) ? S_HALF : S_DONE;
                end
            end
            S_HALF: begin
                busy      = 1'b1;
                half      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt holds the number of full rounds already applied to st_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            rc   <= C0;
            cnt  <= '0;
        end else if (load) begin
            st_q <= state_in;
            rc   <= C0;
            cnt  <= '0;
        end else if (adv) begin
            st_q <= st_run;
            rc   <= rc_run;
            cnt  <= cnt + CNT_STEP;
        end else if (half) begin
            st_q <= sub_layer(st_q, rc);
        end
    end

    assign state_out = st_q;

endmodule
